sb_rx_transaction_decoder: RTL and testbench
============================================

// Module: sb_rx_transaction_decoder
// PURPOSE
// - Sideband receive path of the logical layer; the inverse of the sbtx transaction encoder.
// - Deserializes the sbrx line (1 bit per sb_clk, UART-style) and parses DLE-framed transactions.
// - Delivers AT/command transactions and LT (lane-transition) symbols to the LT/CL0 control FSM.
// PARAMETERS
// - MAX_BYTES  64  max payload bytes kept per transaction, excluding STX and CRC
// PORTS
// - sb_clk       in   1             sideband clock; one sbrx bit sampled per rising edge
// - rst          in   1             asynchronous, active-high reset
// - sbrx         in   1             serial sideband input; idle high
// - trans_valid  out  1             1-cycle pulse: transaction completed and accepted
// - trans_stx    out  8             STX/command byte of the last transaction
// - trans_data   out  8*MAX_BYTES   payload; byte i is bits [8i+7:8i]
// - trans_len    out  $clog2(MAX_BYTES+1)  payload byte count
// - lt_valid     out  1             1-cycle pulse: valid LSE/CLSE pair received
// - lt_lse       out  8             LSE code of the last LT symbol
// - frame_err    out  1             1-cycle pulse on any framing/format error
// - crc_err      out  1             1-cycle pulse: ETX reached but CRC mismatch
// BEHAVIOUR
// - Reset: all outputs 0; both FSMs in IDLE; CRC register 16'hFFFF. Async assert aborts any frame.
// - Byte FSM: B_IDLE -(sbrx==0)-> B_DATA (8 bits, LSB first) -> B_STOP.
//   - B_STOP, sbrx==1: byte strobe to parser, then B_IDLE.
//   - B_STOP, sbrx==0: frame_err; parser -> P_IDLE; B_WAIT until sbrx==1.
// - Parser FSM (advances on byte strobe only):
//   - P_IDLE: 8'hFE (DLE) -> P_TYPE; other bytes ignored.
//   - P_TYPE:
//     - byte[7]==1 and byte!=8'hFE -> capture LSE, P_CLSE.
//     - byte[7]==0 and byte!=8'h40 -> store STX, CRC over it, len=0, P_PAY.
//     - else -> frame_err, P_IDLE.
//   - P_CLSE: byte==~LSE -> lt_lse=LSE, lt_valid; else frame_err. Then P_IDLE.
//   - P_PAY: byte!=DLE -> append; byte==DLE -> P_ESC.
//   - P_ESC:
//     - DLE -> append 8'hFE (byte stuffing), P_PAY.
//     - 8'h40 (ETX) -> finish.
//     - else -> frame_err, P_IDLE.
// - Buffering: the last 2 appended bytes are the CRC (low byte first), held in a 2-byte delay
//   line; only bytes leaving the delay line enter trans_data and the CRC.
// - CRC-16: poly 0x8005, init 16'hFFFF, bits fed LSB first, no final XOR; covers STX+payload.
// - Finish (cycle after ETX stop bit):
//   - fewer than 2 bytes after STX -> frame_err.
//   - else CRC mismatch -> crc_err.
//   - else trans_stx/data/len update and trans_valid pulses in the same cycle.
// - Overflow: more than MAX_BYTES+2 bytes after STX -> frame_err, P_IDLE.
// - Data outputs hold their last value until the next accepted transaction; unused trans_data bytes read 0.
// - Total latency: trans_valid 1 sb_clk after the ETX stop-bit sample; lt_valid 1 sb_clk after the CLSE stop bit.
// - The pulses are mutually exclusive per cycle.
// - A DLE in P_TYPE/P_CLSE is not a restart; an error is flagged first.
// CONFIGURATION
// - SB_RX_CRC_CHECK_EN defined: CRC computed and compared as above; crc_err functional.
// - Not defined: CRC logic removed; CRC bytes still stripped; crc_err tied 0; ETX always accepts.
// TESTING
// - Idle 20 cycles, then DLE,STX=8'h05,8'h01,8'h02,CRC,DLE,ETX
//   -> trans_valid one cycle after last stop; stx=05, len=2, data[15:0]=16'h0201.
// - Payload byte 8'hFE sent as DLE,DLE -> len=1, data[7:0]=8'hFE, no error.
// - DLE,8'h80,8'h7F -> lt_valid, lt_lse=8'h80; DLE,8'h80,8'h7E -> frame_err, no lt_valid.
// - Valid frame with one CRC bit flipped -> crc_err pulse, trans_valid stays 0, outputs keep old values.
//   Without the macro: trans_valid=1.
// - Stop bit forced 0 mid-payload -> frame_err; following valid frame decodes correctly.
// - rst pulsed mid-payload, then a clean frame -> outputs 0 after reset; second frame decodes with correct len.

Source files
------------

// File: rtl/sb_rx_transaction_decoder.sv
// rtl/sb_rx_transaction_decoder.sv - sideband rx deserializer and DLE-framed transaction parser
//
// Purpose: samples the UART-style sbrx line (start bit, 8 data bits LSB first, stop bit,
// one bit per sb_clk), then parses DLE-framed AT/command transactions and LT symbols.
// Transactions carry STX, payload and a trailing 2-byte CRC (low byte first), closed by DLE,ETX.
//
// Ports:
//   sb_clk       sideband clock, one sbrx bit per rising edge
//   rst          asynchronous active-high reset
//   sbrx         serial input, idle high
//   trans_valid  1-cycle pulse, transaction accepted
//   trans_stx    STX/command byte of the last accepted transaction
//   trans_data   payload, byte i at [8i+7:8i], unused bytes 0
//   trans_len    payload byte count
//   lt_valid     1-cycle pulse, valid LSE/CLSE pair
//   lt_lse       LSE code of the last LT symbol
//   frame_err    1-cycle pulse on any framing/format error
//   crc_err      1-cycle pulse on CRC mismatch at ETX
//
// Configuration macro: SB_RX_CRC_CHECK_EN enables CRC-16 checking (poly 0x8005, init 0xFFFF,
// LSB-first bit feed, no final XOR). Without it the CRC bytes are still stripped, crc_err is 0
// and every well-formed ETX is accepted.

module sb_rx_transaction_decoder #(
    parameter int  MAX_BYTES = 64,
    localparam int LEN_W     = $clog2(MAX_BYTES + 1),
    localparam int CNT_W     = $clog2(MAX_BYTES + 3)
) (
    input  logic                   sb_clk,
    input  logic                   rst,
    input  logic                   sbrx,
    output logic                   trans_valid,
    output logic [7:0]             trans_stx,
    output logic [8*MAX_BYTES-1:0] trans_data,
    output logic [LEN_W-1:0]       trans_len,
    output logic                   lt_valid,
    output logic [7:0]             lt_lse,
    output logic                   frame_err,
    output logic                   crc_err
);

    localparam logic [7:0] DLE = 8'hFE;
    localparam logic [7:0] ETX = 8'h40;

    typedef enum logic [1:0] {B_IDLE, B_DATA, B_STOP, B_WAIT} bstate_t;
    typedef enum logic [2:0] {P_IDLE, P_TYPE, P_CLSE, P_PAY, P_ESC} pstate_t;

    bstate_t                bstate_q, bstate_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             sh_q, sh_d;
    logic                   strobe_q, strobe_d;
    logic [7:0]             rx_byte_q, rx_byte_d;

    pstate_t                pstate_q, pstate_d;
    logic [7:0]             lse_q, lse_d;
    logic [7:0]             stx_q, stx_d;
    logic [CNT_W-1:0]       app_cnt_q, app_cnt_d;
    logic [7:0]             dl0_q, dl0_d;
    logic [7:0]             dl1_q, dl1_d;
    logic [8*MAX_BYTES-1:0] pay_buf_q, pay_buf_d;

    logic                   trans_valid_q, trans_valid_d;
    logic [7:0]             trans_stx_q, trans_stx_d;
    logic [8*MAX_BYTES-1:0] trans_data_q, trans_data_d;
    logic [LEN_W-1:0]       trans_len_q, trans_len_d;
    logic                   lt_valid_q, lt_valid_d;
    logic [7:0]             lt_lse_q, lt_lse_d;
    logic                   frame_err_q, frame_err_d;

    logic                   stop_err;
    logic                   app_en;
    logic [7:0]             app_byte;
    logic                   crc_bad;

`ifdef SB_RX_CRC_CHECK_EN
    logic [15:0]            crc_q, crc_d;
    logic                   crc_err_q, crc_err_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction
`endif

    always_comb begin
        bstate_d      = bstate_q;
        bit_cnt_d     = bit_cnt_q;
        sh_d          = sh_q;
        strobe_d      = 1'b0;
        rx_byte_d     = rx_byte_q;
        pstate_d      = pstate_q;
        lse_d         = lse_q;
        stx_d         = stx_q;
        app_cnt_d     = app_cnt_q;
        dl0_d         = dl0_q;
        dl1_d         = dl1_q;
        pay_buf_d     = pay_buf_q;
        trans_valid_d = 1'b0;
        trans_stx_d   = trans_stx_q;
        trans_data_d  = trans_data_q;
        trans_len_d   = trans_len_q;
        lt_valid_d    = 1'b0;
        lt_lse_d      = lt_lse_q;
        frame_err_d   = 1'b0;
        stop_err      = 1'b0;
        app_en        = 1'b0;
        app_byte      = rx_byte_q;
        crc_bad       = 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
        crc_d         = crc_q;
        crc_err_d     = 1'b0;
        crc_bad       = (crc_q != {dl0_q, dl1_q});
`endif

        // Byte deserializer
        case (bstate_q)
            B_IDLE: begin
                if (!sbrx) begin
                    bstate_d  = B_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            B_DATA: begin
                sh_d      = {sbrx, sh_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) bstate_d = B_STOP;
            end
            B_STOP: begin
                if (sbrx) begin
                    strobe_d  = 1'b1;
                    rx_byte_d = sh_q;
                    bstate_d  = B_IDLE;
                end else begin
                    stop_err  = 1'b1;
                    bstate_d  = B_WAIT;
                end
            end
            default: begin
                if (sbrx) bstate_d = B_IDLE;
            end
        endcase

        // Transaction parser, one step per received byte
        if (strobe_q) begin
            case (pstate_q)
                P_IDLE: begin
                    if (rx_byte_q == DLE) pstate_d = P_TYPE;
                end
                P_TYPE: begin
                    if (rx_byte_q[7] && rx_byte_q != DLE) begin
                        lse_d    = rx_byte_q;
                        pstate_d = P_CLSE;
                    end else if (!rx_byte_q[7] && rx_byte_q != ETX) begin
                        stx_d     = rx_byte_q;
                        app_cnt_d = '0;
                        pay_buf_d = '0;
`ifdef SB_RX_CRC_CHECK_EN
                        crc_d     = crc_step(16'hFFFF, rx_byte_q);
`endif
                        pstate_d  = P_PAY;
                    end else begin
                        frame_err_d = 1'b1;
                        pstate_d    = P_IDLE;
                    end
                end
                P_CLSE: begin
                    if (rx_byte_q == ~lse_q) begin
                        lt_lse_d   = lse_q;
                        lt_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    pstate_d = P_IDLE;
                end
                P_PAY: begin
                    if (rx_byte_q == DLE) pstate_d = P_ESC;
                    else                  app_en   = 1'b1;
                end
                default: begin
                    if (rx_byte_q == DLE) begin
                        app_en   = 1'b1;
                        pstate_d = P_PAY;
                    end else if (rx_byte_q == ETX) begin
                        pstate_d = P_IDLE;
                        if (app_cnt_q < CNT_W'(2)) begin
                            frame_err_d = 1'b1;
                        end else if (crc_bad) begin
`ifdef SB_RX_CRC_CHECK_EN
                            crc_err_d = 1'b1;
`endif
                        end else begin
                            trans_valid_d = 1'b1;
                            trans_stx_d   = stx_q;
                            trans_data_d  = pay_buf_q;
                            trans_len_d   = LEN_W'(app_cnt_q - CNT_W'(2));
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        pstate_d    = P_IDLE;
                    end
                end
            endcase
        end

        // The two newest bytes may be the CRC, so a byte only reaches the payload
        // buffer and the CRC once two more bytes have arrived behind it.
        if (app_en) begin
            if (app_cnt_q == CNT_W'(MAX_BYTES + 2)) begin
                frame_err_d = 1'b1;
                pstate_d    = P_IDLE;
            end else begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                    if (app_cnt_q == CNT_W'(i + 2)) pay_buf_d[8*i +: 8] = dl1_q;
                end
`ifdef SB_RX_CRC_CHECK_EN
                if (app_cnt_q >= CNT_W'(2)) crc_d = crc_step(crc_q, dl1_q);
`endif
                dl1_d     = dl0_q;
                dl0_d     = app_byte;
                app_cnt_d = app_cnt_q + CNT_W'(1);
            end
        end

        // A broken stop bit abandons whatever frame was in progress
        if (stop_err) begin
            frame_err_d = 1'b1;
            pstate_d    = P_IDLE;
        end
    end

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            bstate_q      <= B_IDLE;
            bit_cnt_q     <= '0;
            sh_q          <= '0;
            strobe_q      <= 1'b0;
            rx_byte_q     <= '0;
            pstate_q      <= P_IDLE;
            lse_q         <= '0;
            stx_q         <= '0;
            app_cnt_q     <= '0;
            dl0_q         <= '0;
            dl1_q         <= '0;
            pay_buf_q     <= '0;
            trans_valid_q <= 1'b0;
            trans_stx_q   <= '0;
            trans_data_q  <= '0;
            trans_len_q   <= '0;
            lt_valid_q    <= 1'b0;
            lt_lse_q      <= '0;
            frame_err_q   <= 1'b0;
`ifdef SB_RX_CRC_CHECK_EN
            crc_q         <= 16'hFFFF;
            crc_err_q     <= 1'b0;
`endif
        end else begin
            bstate_q      <= bstate_d;
            bit_cnt_q     <= bit_cnt_d;
            sh_q          <= sh_d;
            strobe_q      <= strobe_d;
            rx_byte_q     <= rx_byte_d;
            pstate_q      <= pstate_d;
            lse_q         <= lse_d;
            stx_q         <= stx_d;
            app_cnt_q     <= app_cnt_d;
            dl0_q         <= dl0_d;
            dl1_q         <= dl1_d;
            pay_buf_q     <= pay_buf_d;
            trans_valid_q <= trans_valid_d;
            trans_stx_q   <= trans_stx_d;
            trans_data_q  <= trans_data_d;
            trans_len_q   <= trans_len_d;
            lt_valid_q    <= lt_valid_d;
            lt_lse_q      <= lt_lse_d;
            frame_err_q   <= frame_err_d;
`ifdef SB_RX_CRC_CHECK_EN
            crc_q         <= crc_d;
            crc_err_q     <= crc_err_d;
`endif
        end
    end

    assign trans_valid = trans_valid_q;
    assign trans_stx   = trans_stx_q;
    assign trans_data  = trans_data_q;
    assign trans_len   = trans_len_q;
    assign lt_valid    = lt_valid_q;
    assign lt_lse      = lt_lse_q;
    assign frame_err   = frame_err_q;
`ifdef SB_RX_CRC_CHECK_EN
    assign crc_err     = crc_err_q;
`else
    assign crc_err     = 1'b0;
`endif

endmodule

// File: tb/tb_sb_rx_transaction_decoder.sv
// tb/tb_sb_rx_transaction_decoder.sv - self-checking bench for sb_rx_transaction_decoder
`timescale 1ns/1ps
module tb_sb_rx_transaction_decoder;
    localparam int MAX_BYTES = 64;
    localparam int LEN_W     = $clog2(MAX_BYTES + 1);

    typedef logic [7:0] byte_q_t[$];

    logic                   sb_clk = 1'b0;
    logic                   rst;
    logic                   sbrx;
    logic                   trans_valid;
    logic [7:0]             trans_stx;
    logic [8*MAX_BYTES-1:0] trans_data;
    logic [LEN_W-1:0]       trans_len;
    logic                   lt_valid;
    logic [7:0]             lt_lse;
    logic                   frame_err;
    logic                   crc_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: what the outputs should hold after the last accepted transaction
    logic [7:0]             m_stx;
    logic [8*MAX_BYTES-1:0] m_data;
    int                     m_len;
    logic [7:0]             m_lse;

    always #5 sb_clk = ~sb_clk;

    sb_rx_transaction_decoder #(.MAX_BYTES(MAX_BYTES)) dut (
        .sb_clk      (sb_clk),
        .rst         (rst),
        .sbrx        (sbrx),
        .trans_valid (trans_valid),
        .trans_stx   (trans_stx),
        .trans_data  (trans_data),
        .trans_len   (trans_len),
        .lt_valid    (lt_valid),
        .lt_lse      (lt_lse),
        .frame_err   (frame_err),
        .crc_err     (crc_err)
    );

    always @(negedge sb_clk) begin
        if (!rst && (trans_valid || lt_valid || frame_err || crc_err)) begin
            vectors++;
            if (int'(trans_valid) + int'(lt_valid) + int'(frame_err) + int'(crc_err) > 1) begin
                miscompares++;
                $display("FAIL pulse_exclusive: tv=%0b lt=%0b fe=%0b ce=%0b, required at most one",
                         trans_valid, lt_valid, frame_err, crc_err);
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    function automatic logic [15:0] model_crc(input logic [7:0] stx, input byte_q_t p);
        byte_q_t     msg;
        logic [15:0] c;
        logic        top;
        msg = p;
        msg.push_front(stx);
        c = 16'hFFFF;
        foreach (msg[k]) begin
            for (int i = 0; i < 8; i++) begin
                top = c[15];
                c   = c << 1;
                if (top ^ msg[k][i]) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge sb_clk) sbrx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sb_clk) sbrx = b[i];
        end
        @(negedge sb_clk) sbrx = 1'b1;
    endtask

    task automatic send_stuffed(input logic [7:0] b);
        send_byte(b);
        if (b == 8'hFE) send_byte(8'hFE);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge sb_clk) sbrx = 1'b1;
    endtask

    // Sends one framed transaction and checks the outcome the reference predicts
    task automatic run_frame(input string nm, input logic [7:0] stx, input byte_q_t p,
                             input logic [15:0] flip);
        logic [15:0] c;
        int          kind;
        c = model_crc(stx, p) ^ flip;
        send_byte(8'hFE);
        send_byte(stx);
        foreach (p[i]) send_stuffed(p[i]);
        send_stuffed(c[7:0]);
        send_stuffed(c[15:8]);
        send_byte(8'hFE);
        send_byte(8'h40);
`ifdef SB_RX_CRC_CHECK_EN
        kind = (flip != 16'h0) ? 1 : 0;
`else
        kind = 0;
`endif
        if (kind == 0) begin
            m_stx  = stx;
            m_len  = p.size();
            m_data = '0;
            foreach (p[i]) m_data[8*i +: 8] = p[i];
        end
        @(negedge sb_clk);
        vectors++;
        if (trans_valid !== 1'b0 || crc_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s early_pulse: tv=%0b ce=%0b, required 0 0", nm, trans_valid, crc_err);
        end
        @(negedge sb_clk);
        vectors++;
        if (trans_valid !== (kind == 0) || crc_err !== (kind == 1) || frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s outcome: tv=%0b ce=%0b fe=%0b, required %0b %0b 0",
                     nm, trans_valid, crc_err, frame_err, kind == 0, kind == 1);
        end
        vectors++;
        if (trans_stx !== m_stx || trans_len !== LEN_W'(m_len) || trans_data !== m_data) begin
            miscompares++;
            $display("FAIL %s outputs: stx=%h len=%0d data=%h, required stx=%h len=%0d data=%h",
                     nm, trans_stx, trans_len, trans_data, m_stx, m_len, m_data);
        end
        @(negedge sb_clk);
        vectors++;
        if (trans_valid !== 1'b0 || crc_err !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse_width: tv=%0b ce=%0b, required 0 0", nm, trans_valid, crc_err);
        end
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        sbrx = 1'b1;
        m_stx = '0; m_data = '0; m_len = 0; m_lse = '0;
        repeat (3) @(negedge sb_clk);
        vectors++;
        if (trans_valid !== 1'b0 || lt_valid !== 1'b0 || frame_err !== 1'b0 || crc_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses: tv=%0b lt=%0b fe=%0b ce=%0b, required all 0",
                     trans_valid, lt_valid, frame_err, crc_err);
        end
        vectors++;
        if (trans_stx !== 8'h0 || trans_len !== '0 || trans_data !== '0 || lt_lse !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_data: stx=%h len=%0d lse=%h, required 0", trans_stx, trans_len, lt_lse);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        byte_q_t p;
        idle(20);
        p = {8'h01, 8'h02};
        run_frame("basic", 8'h05, p, 16'h0);
        vectors++;
        if (trans_data[15:0] !== 16'h0201 || trans_len !== LEN_W'(2) || trans_stx !== 8'h05) begin
            miscompares++;
            $display("FAIL basic_const: data=%h len=%0d stx=%h, required 0201 2 05",
                     trans_data[15:0], trans_len, trans_stx);
        end
        p = {};
        run_frame("empty_payload", 8'h3C, p, 16'h0);
    endtask

    task automatic test_stuffing;
        byte_q_t p;
        p = {8'hFE};
        run_frame("stuff", 8'h11, p, 16'h0);
        vectors++;
        if (trans_data[7:0] !== 8'hFE || trans_len !== LEN_W'(1)) begin
            miscompares++;
            $display("FAIL stuff_const: data=%h len=%0d, required FE 1", trans_data[7:0], trans_len);
        end
    endtask

    task automatic test_lt;
        logic [7:0] l;
        for (int n = 0; n < 5; n++) begin
            l = (n == 0) ? 8'h80 : 8'($urandom_range(128, 253));
            if (n == 4) l = 8'hFF;
            send_byte(8'hFE); send_byte(l); send_byte(~l);
            m_lse = l;
            @(negedge sb_clk);
            @(negedge sb_clk);
            vectors++;
            if (lt_valid !== 1'b1 || lt_lse !== m_lse || frame_err !== 1'b0) begin
                miscompares++;
                $display("FAIL lt_good: lt=%0b lse=%h fe=%0b, required 1 %h 0", lt_valid, lt_lse, frame_err, m_lse);
            end
        end
        send_byte(8'hFE); send_byte(8'h80); send_byte(8'h7E);
        @(negedge sb_clk);
        @(negedge sb_clk);
        vectors++;
        if (lt_valid !== 1'b0 || frame_err !== 1'b1 || lt_lse !== m_lse) begin
            miscompares++;
            $display("FAIL lt_bad: lt=%0b fe=%0b lse=%h, required 0 1 %h", lt_valid, frame_err, lt_lse, m_lse);
        end
        // DLE or ETX in the type position is an error, not a restart
        send_byte(8'hFE); send_byte(8'hFE);
        @(negedge sb_clk);
        @(negedge sb_clk);
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL type_dle: fe=%0b, required 1", frame_err);
        end
        send_byte(8'hFE); send_byte(8'h40);
        @(negedge sb_clk);
        @(negedge sb_clk);
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL type_etx: fe=%0b, required 1", frame_err);
        end
    endtask

    task automatic test_short;
        for (int n = 0; n < 2; n++) begin
            send_byte(8'hFE); send_byte(8'h05);
            if (n == 1) send_byte(8'hAA);
            send_byte(8'hFE); send_byte(8'h40);
            @(negedge sb_clk);
            @(negedge sb_clk);
            vectors++;
            if (frame_err !== 1'b1 || trans_valid !== 1'b0 || trans_stx !== m_stx || trans_len !== LEN_W'(m_len)) begin
                miscompares++;
                $display("FAIL short_%0d: fe=%0b tv=%0b stx=%h len=%0d, required 1 0 %h %0d",
                         n, frame_err, trans_valid, trans_stx, trans_len, m_stx, m_len);
            end
        end
    endtask

    task automatic test_crc_err;
        byte_q_t p;
        p = {8'h01, 8'h02, 8'h03};
        run_frame("crc_flip", 8'h05, p, 16'h0100);
    endtask

    task automatic test_stop_err;
        byte_q_t p;
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h01);
        @(negedge sb_clk) sbrx = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge sb_clk) sbrx = 1'($urandom_range(0, 1));
        @(negedge sb_clk) sbrx = 1'b0;
        @(negedge sb_clk) sbrx = 1'b1;
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_err: fe=%0b, required 1", frame_err);
        end
        idle(2);
        p = {8'h5A, 8'hA5, 8'hFE, 8'h00};
        run_frame("after_stop_err", 8'h22, p, 16'h0);
    endtask

    task automatic test_overflow;
        byte_q_t p;
        send_byte(8'hFE); send_byte(8'h22);
        for (int i = 0; i < MAX_BYTES + 3; i++) send_byte(8'h33);
        @(negedge sb_clk);
        @(negedge sb_clk);
        vectors++;
        if (frame_err !== 1'b1 || trans_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow: fe=%0b tv=%0b, required 1 0", frame_err, trans_valid);
        end
        p = {};
        for (int i = 0; i < MAX_BYTES; i++) p.push_back(8'($urandom_range(0, 255)));
        run_frame("max_len", 8'h01, p, 16'h0);
    endtask

    task automatic test_reset_mid;
        byte_q_t p;
        send_byte(8'hFE); send_byte(8'h07); send_byte(8'h01); send_byte(8'h02);
        @(negedge sb_clk) rst = 1'b1;
        #1;
        m_stx = '0; m_data = '0; m_len = 0;
        vectors++;
        if (trans_stx !== 8'h0 || trans_len !== '0 || trans_data !== '0 || lt_lse !== 8'h0) begin
            miscompares++;
            $display("FAIL reset_mid: stx=%h len=%0d lse=%h, required 0", trans_stx, trans_len, lt_lse);
        end
        @(negedge sb_clk) rst = 1'b0;
        idle(3);
        p = {8'hA1, 8'hB2, 8'hC3};
        run_frame("after_reset", 8'h09, p, 16'h0);
    endtask

    task automatic test_random;
        byte_q_t     p;
        logic [7:0]  s;
        logic [15:0] f;
        int          len;
        for (int n = 0; n < 16; n++) begin
            s = 8'($urandom_range(0, 127));
            while (s == 8'h40) s = 8'($urandom_range(0, 127));
            len = $urandom_range(0, 12);
            if (n == 3) len = MAX_BYTES;
            p = {};
            for (int i = 0; i < len; i++)
                p.push_back(($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255)));
            f = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            run_frame("random", s, p, f);
            idle($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stuffing;
        test_lt;
        test_short;
        test_crc_err;
        test_stop_err;
        test_overflow;
        test_reset_mid;
        test_random;
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
